// File: rtl/conv_mac_accumulator_if.sv
// rtl/conv_mac_accumulator_if.sv - tap stream and window result bundle for conv_mac_accumulator
//
// Purpose: groups the pixel/weight tap handshake, the abort strobe and the
// completed-window result signals of conv_mac_accumulator.
//
// Signals:
//   in_valid        master->slave  pixel/weight pair presented
//   in_ready        slave->master  pair accepted this cycle
//   pixel           master->slave  unsigned pixel, PIX_WIDTH bits
//   weight          master->slave  signed weight, WGT_WIDTH bits
//   clear           master->slave  abort of the partial window
//   acc_out         slave->master  completed window sum, DATA_WIDTH bits
//   load_new_value  slave->master  one-cycle pulse, acc_out valid
//   busy            slave->master  window partially accumulated
interface conv_mac_accumulator_if #(
  parameter int DATA_WIDTH = 20,
  parameter int PIX_WIDTH  = 8,
  parameter int WGT_WIDTH  = 8
);
  logic                         in_valid;
  logic                         in_ready;
  logic [PIX_WIDTH-1:0]         pixel;
  logic signed [WGT_WIDTH-1:0]  weight;
  logic                         clear;
  logic signed [DATA_WIDTH-1:0] acc_out;
  logic                         load_new_value;
  logic                         busy;

  modport master (
    output in_valid, pixel, weight, clear,
    input  in_ready, acc_out, load_new_value, busy
  );

  modport slave (
    input  in_valid, pixel, weight, clear,
    output in_ready, acc_out, load_new_value, busy
  );
endinterface

// File: rtl/conv_mac_accumulator.sv
// rtl/conv_mac_accumulator.sv - saturating multiply-accumulate over fixed-length convolution windows
//
// Purpose: accumulates KERNEL_TAPS pixel*weight products per window through a
// two-stage pipeline (product register, saturating accumulator) and publishes
// each completed window sum with a one-cycle load_new_value pulse.
//
// Ports:
//   clk  input  single clock, rising edge
//   rst  input  asynchronous active-low reset
//   bus  conv_mac_accumulator_if.slave
//        in_valid/in_ready/pixel/weight  tap handshake
//        clear                           abort of the partial window
//        acc_out/load_new_value          completed window sum and its strobe
//        busy                            window partially accumulated
module conv_mac_accumulator #(
  parameter int DATA_WIDTH  = 20,
  parameter int PIX_WIDTH   = 8,
  parameter int WGT_WIDTH   = 8,
  parameter int KERNEL_TAPS = 9
) (
  input logic                   clk,
  input logic                   rst,
  conv_mac_accumulator_if.slave bus
);

  // Pixel gets one extra zero bit to become signed before the multiply.
  localparam int PROD_W = PIX_WIDTH + 1 + WGT_WIDTH;
  // One guard bit above the wider operand so the add can never wrap.
  localparam int SUM_W = ((DATA_WIDTH > PROD_W) ? DATA_WIDTH : PROD_W) + 1;
  localparam logic [7:0] LAST_CNT = 8'(KERNEL_TAPS - 1);
  localparam logic signed [SUM_W-1:0] SAT_MAX =
    {{(SUM_W - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_MIN =
    {{(SUM_W - DATA_WIDTH + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_ACCUM = 1'b1
  } state_t;

  state_t                        r_state;
  state_t                        w_state_nxt;
  logic [7:0]                    r_count;
  logic [7:0]                    w_count_nxt;
  logic                          w_accept;
  logic                          w_first;
  logic                          w_last;

  logic signed [PROD_W-1:0]      w_pix_s;
  logic signed [PROD_W-1:0]      w_wgt_s;
  logic signed [PROD_W-1:0]      w_prod;
  logic                          r_s1_valid;
  logic                          r_s1_first;
  logic                          r_s1_last;
  logic signed [PROD_W-1:0]      r_s1_prod;

  logic signed [SUM_W-1:0]       w_base;
  logic signed [SUM_W-1:0]       w_prod_ext;
  logic signed [SUM_W-1:0]       w_sum;
  logic signed [DATA_WIDTH-1:0]  w_sat;
  logic signed [DATA_WIDTH-1:0]  r_acc;
  logic                          r_s2_done;
  logic signed [DATA_WIDTH-1:0]  r_acc_out;
  logic                          r_load;

  // Held low during reset so no tap is taken before the pipeline is known-empty.
  assign bus.in_ready = rst && !bus.clear;
  assign w_accept     = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_first     = 1'b0;
    w_last      = 1'b0;
    if (bus.clear) begin
      w_state_nxt = S_IDLE;
      w_count_nxt = '0;
    end else if (w_accept) begin
      case (r_state)
        S_IDLE: begin
          w_first     = 1'b1;
          w_state_nxt = S_ACCUM;
          w_count_nxt = 8'd1;
        end
        S_ACCUM: begin
          if (r_count == LAST_CNT) begin
            w_last      = 1'b1;
            w_state_nxt = S_IDLE;
            w_count_nxt = '0;
          end else begin
            w_count_nxt = r_count + 8'd1;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_count_nxt = '0;
        end
      endcase
    end
  end

  assign w_pix_s = {{(WGT_WIDTH + 1){1'b0}}, bus.pixel};
  assign w_wgt_s = {{(PIX_WIDTH + 1){bus.weight[WGT_WIDTH-1]}}, bus.weight};
  assign w_prod  = w_pix_s * w_wgt_s;

  // A first tap restarts the window, so it is added to zero instead of the
  // previous sum; the load still passes through the clamp for narrow accumulators.
  assign w_base     = r_s1_first ? '0 : {{(SUM_W - DATA_WIDTH){r_acc[DATA_WIDTH-1]}}, r_acc};
  assign w_prod_ext = {{(SUM_W - PROD_W){r_s1_prod[PROD_W-1]}}, r_s1_prod};
  assign w_sum      = w_base + w_prod_ext;

  always_comb begin
    w_sat = w_sum[DATA_WIDTH-1:0];
    if (w_sum > SAT_MAX) begin
      w_sat = SAT_MAX[DATA_WIDTH-1:0];
    end else if (w_sum < SAT_MIN) begin
      w_sat = SAT_MIN[DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_valid <= 1'b0;
      r_s1_first <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_prod  <= '0;
      r_acc      <= '0;
      r_s2_done  <= 1'b0;
      r_acc_out  <= '0;
      r_load     <= 1'b0;
    end else begin
      // w_accept is already low under clear, which empties stage 1.
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_prod  <= w_prod;
        r_s1_first <= w_first;
        r_s1_last  <= w_last;
      end
      if (bus.clear) begin
        r_acc <= '0;
      end else if (r_s1_valid) begin
        r_acc <= w_sat;
      end
      // A last tap still in stage 1 under clear is dropped; one that has
      // already reached stage 2 (r_s2_done) completes normally below.
      r_s2_done <= r_s1_valid && r_s1_last && !bus.clear;
      if (r_s2_done) begin
        r_acc_out <= r_acc;
      end
      r_load <= r_s2_done;
    end
  end

  assign bus.acc_out        = r_acc_out;
  assign bus.load_new_value = r_load;
  assign bus.busy           = (r_state == S_ACCUM) || (r_s1_valid && !r_s1_last);

endmodule

// File: tb/tb_conv_mac_accumulator.sv
// tb/tb_conv_mac_accumulator.sv - randomized self-checking bench for conv_mac_accumulator
module tb_conv_mac_accumulator;
  localparam int K = 9;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  conv_mac_accumulator_if #(.DATA_WIDTH(20), .PIX_WIDTH(8), .WGT_WIDTH(8)) if_a ();
  conv_mac_accumulator_if #(.DATA_WIDTH(16), .PIX_WIDTH(8), .WGT_WIDTH(8)) if_b ();

  conv_mac_accumulator #(.DATA_WIDTH(20), .PIX_WIDTH(8), .WGT_WIDTH(8), .KERNEL_TAPS(K)) dut_a (
    .clk(clk), .rst(rst), .bus(if_a.slave)
  );
  conv_mac_accumulator #(.DATA_WIDTH(16), .PIX_WIDTH(8), .WGT_WIDTH(8), .KERNEL_TAPS(K)) dut_b (
    .clk(clk), .rst(rst), .bus(if_b.slave)
  );

  int n_pass  = 0;
  int n_total = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned cyc;
    logic        la;
    logic        lb;
    longint      acc_a;
    longint      acc_b;
  } obs_t;
  typedef struct {
    int unsigned cyc;
    longint      sum_a;
    longint      sum_b;
  } exp_t;
  obs_t obs_q[$];
  exp_t exp_q[$];

  always @(negedge clk) begin
    if (if_a.load_new_value || if_b.load_new_value)
      obs_q.push_back('{cyc, if_a.load_new_value, if_b.load_new_value,
                        longint'(if_a.acc_out), longint'(if_b.acc_out)});
  end

  // Reference model: window sums by plain arithmetic, clamped after every product.
  int     m_count = 0;
  longint m_sum_a = 0;
  longint m_sum_b = 0;

  function automatic longint sat(longint v, int w);
    longint hi;
    longint lo;
    hi = (longint'(1) <<< (w - 1)) - 1;
    lo = -hi - 1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  task automatic model_accept(int p, int w);
    longint prod;
    prod = longint'(p) * longint'(w);
    if (m_count == 0) begin
      m_sum_a = sat(prod, 20);
      m_sum_b = sat(prod, 16);
    end else begin
      m_sum_a = sat(m_sum_a + prod, 20);
      m_sum_b = sat(m_sum_b + prod, 16);
    end
    m_count++;
    if (m_count == K) begin
      exp_q.push_back('{cyc, m_sum_a, m_sum_b});
      m_count = 0;
    end
  endtask

  task automatic drive(bit v, int p, int w, bit c);
    if_a.in_valid = v; if_a.pixel = 8'(p); if_a.weight = 8'(w); if_a.clear = c;
    if_b.in_valid = v; if_b.pixel = 8'(p); if_b.weight = 8'(w); if_b.clear = c;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tap(int p, int w);
    drive(1'b1, p, w, 1'b0);
    step();
    model_accept(p, w);
  endtask

  task automatic gap();
    drive(1'b0, 0, 0, 1'b0);
    step();
  endtask

  task automatic settle(int n);
    drive(1'b0, 0, 0, 1'b0);
    repeat (n) step();
  endtask

  task automatic test_reset();
    drive(1'b0, 0, 0, 1'b0);
    #1 rst = 1'b0;
    #1;
    n_total++;
    if (if_a.acc_out !== 20'sd0 || if_b.acc_out !== 16'sd0) $display("FAIL reset_acc_out: got %0d/%0d want 0", if_a.acc_out, if_b.acc_out);
    else n_pass++;
    n_total++;
    if (if_a.load_new_value !== 1'b0 || if_a.busy !== 1'b0) $display("FAIL reset_flags: load=%b busy=%b want 0 0", if_a.load_new_value, if_a.busy);
    else n_pass++;
    n_total++;
    if (if_a.in_ready !== 1'b0 || if_b.in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b/%b want 0", if_a.in_ready, if_b.in_ready);
    else n_pass++;
    repeat (3) step();
    rst = 1'b1;
    step();
    n_total++;
    if (if_a.in_ready !== 1'b1 || if_b.in_ready !== 1'b1) $display("FAIL release_in_ready: got %b/%b want 1", if_a.in_ready, if_b.in_ready);
    else n_pass++;
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_constant_windows();
    int tp[3]  = '{1, 255, 255};
    int tw[3]  = '{1, -128, 127};
    int ta[3]  = '{9, -293760, 291465};
    int tb_[3] = '{9, -32768, 32767};
    for (int t = 0; t < 3; t++) begin
      tap(tp[t], tw[t]);
      n_total++;
      if (if_a.busy !== 1'b1 || if_b.busy !== 1'b1) $display("FAIL const_busy[%0d]: got %b/%b want 1", t, if_a.busy, if_b.busy);
      else n_pass++;
      for (int i = 1; i < K; i++) tap(tp[t], tw[t]);
      settle(4);
      n_total++;
      if (if_a.busy !== 1'b0) $display("FAIL const_idle_busy[%0d]: got %b want 0", t, if_a.busy);
      else n_pass++;
      n_total++;
      if (obs_q.size() != exp_q.size()) $display("FAIL const_pulses[%0d]: got %0d want %0d", t, obs_q.size(), exp_q.size());
      else n_pass++;
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        n_total++;
        if (obs_q[i].cyc !== exp_q[i].cyc + 2 || obs_q[i].la !== 1'b1 || obs_q[i].lb !== 1'b1)
          $display("FAIL const_timing[%0d]: got cyc %0d (%b%b) want cyc %0d (11)", t, obs_q[i].cyc, obs_q[i].la, obs_q[i].lb, exp_q[i].cyc + 2);
        else n_pass++;
        n_total++;
        if (obs_q[i].acc_a !== exp_q[i].sum_a || obs_q[i].acc_b !== exp_q[i].sum_b)
          $display("FAIL const_model[%0d]: got %0d/%0d want %0d/%0d", t, obs_q[i].acc_a, obs_q[i].acc_b, exp_q[i].sum_a, exp_q[i].sum_b);
        else n_pass++;
        n_total++;
        if (obs_q[i].acc_a !== longint'(ta[t]) || obs_q[i].acc_b !== longint'(tb_[t]))
          $display("FAIL const_value[%0d]: got %0d/%0d want %0d/%0d", t, obs_q[i].acc_a, obs_q[i].acc_b, ta[t], tb_[t]);
        else n_pass++;
      end
      obs_q.delete();
      exp_q.delete();
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < K; i++) tap(2, 2);
    for (int i = 0; i < K; i++) tap(1, 1);
    settle(4);
    n_total++;
    if (obs_q.size() != 2 || exp_q.size() != 2) $display("FAIL b2b_pulses: got %0d want 2", obs_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_total++;
      if (obs_q[i].cyc !== exp_q[i].cyc + 2 || obs_q[i].la !== 1'b1 || obs_q[i].lb !== 1'b1)
        $display("FAIL b2b_timing[%0d]: got cyc %0d want %0d", i, obs_q[i].cyc, exp_q[i].cyc + 2);
      else n_pass++;
      n_total++;
      if (obs_q[i].acc_a !== exp_q[i].sum_a || obs_q[i].acc_b !== exp_q[i].sum_b)
        $display("FAIL b2b_value[%0d]: got %0d/%0d want %0d/%0d", i, obs_q[i].acc_a, obs_q[i].acc_b, exp_q[i].sum_a, exp_q[i].sum_b);
      else n_pass++;
    end
    n_total++;
    if (obs_q.size() < 2 || obs_q[1].cyc - obs_q[0].cyc != 9 || obs_q[0].acc_a != 36 || obs_q[1].acc_a != 9)
      $display("FAIL b2b_spacing: got %0d pulses, want 36 then 9 nine cycles apart", obs_q.size());
    else n_pass++;
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_clear();
    for (int i = 0; i < 5; i++) tap($urandom_range(0, 255), int'($urandom_range(0, 255)) - 128);
    drive(1'b1, 7, 7, 1'b1);
    #1;
    n_total++;
    if (if_a.in_ready !== 1'b0) $display("FAIL clear_in_ready: got %b want 0", if_a.in_ready);
    else n_pass++;
    step();
    m_count = 0;
    n_total++;
    if (if_a.busy !== 1'b0 || if_b.busy !== 1'b0) $display("FAIL clear_busy: got %b/%b want 0", if_a.busy, if_b.busy);
    else n_pass++;
    for (int i = 0; i < K; i++) tap(1, 1);
    settle(4);
    n_total++;
    if (obs_q.size() != 1 || exp_q.size() != 1) $display("FAIL clear_pulses: got %0d want 1", obs_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_total++;
      if (obs_q[i].cyc !== exp_q[i].cyc + 2 || obs_q[i].acc_a !== 64'sd9 || obs_q[i].acc_b !== exp_q[i].sum_b)
        $display("FAIL clear_value: got %0d at cyc %0d want 9 at cyc %0d", obs_q[i].acc_a, obs_q[i].cyc, exp_q[i].cyc + 2);
      else n_pass++;
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset_mid_window();
    for (int i = 0; i < K; i++) tap(2, 1);
    settle(4);
    obs_q.delete();
    exp_q.delete();
    for (int i = 0; i < 4; i++) tap(5, 5);
    #2 rst = 1'b0;
    #1;
    n_total++;
    if (if_a.acc_out !== 20'sd0 || if_b.acc_out !== 16'sd0 || if_a.busy !== 1'b0 || if_a.load_new_value !== 1'b0)
      $display("FAIL midrst_async: acc %0d/%0d busy %b load %b want 0", if_a.acc_out, if_b.acc_out, if_a.busy, if_a.load_new_value);
    else n_pass++;
    drive(1'b0, 0, 0, 1'b0);
    repeat (3) step();
    rst = 1'b1;
    m_count = 0;
    step();
    for (int i = 0; i < K; i++) tap(3, 1);
    settle(4);
    n_total++;
    if (obs_q.size() != 1 || exp_q.size() != 1) $display("FAIL midrst_pulses: got %0d want 1", obs_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_total++;
      if (obs_q[i].cyc !== exp_q[i].cyc + 2 || obs_q[i].acc_a !== 64'sd27 || obs_q[i].acc_b !== exp_q[i].sum_b)
        $display("FAIL midrst_value: got %0d at cyc %0d want 27 at cyc %0d", obs_q[i].acc_a, obs_q[i].cyc, exp_q[i].cyc + 2);
      else n_pass++;
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_random();
    int r;
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 99);
      if (r < 72) begin
        tap($urandom_range(0, 255), int'($urandom_range(0, 255)) - 128);
      end else if (r < 94 || m_count == 0) begin
        gap();
      end else begin
        drive(1'b1, 0, 0, 1'b1);
        step();
        m_count = 0;
      end
    end
    settle(4);
    n_total++;
    if (obs_q.size() != exp_q.size()) $display("FAIL rand_pulses: got %0d want %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_total++;
      if (obs_q[i].cyc !== exp_q[i].cyc + 2 || obs_q[i].la !== 1'b1 || obs_q[i].lb !== 1'b1)
        $display("FAIL rand_timing[%0d]: got cyc %0d want %0d", i, obs_q[i].cyc, exp_q[i].cyc + 2);
      else n_pass++;
      n_total++;
      if (obs_q[i].acc_a !== exp_q[i].sum_a || obs_q[i].acc_b !== exp_q[i].sum_b)
        $display("FAIL rand_value[%0d]: got %0d/%0d want %0d/%0d", i, obs_q[i].acc_a, obs_q[i].acc_b, exp_q[i].sum_a, exp_q[i].sum_b);
      else n_pass++;
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    drive(1'b0, 0, 0, 1'b0);
    test_reset();
    test_constant_windows();
    test_back_to_back();
    test_clear();
    test_reset_mid_window();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
